// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM (BOOT/IF/ID/EX/MEM/WB/TRAP) with per-wait ack watchdog and illegal-opcode trap.
// Define CTRL_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl #(
    parameter int PCMUX_N = 2,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 32
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [6:0]                                        opcode,
    input  logic                                              br_taken,
    input  logic                                              imem_ack,
    input  logic                                              ex_valid,
    input  logic                                              dmem_ack,
    output logic                                              instrre,
    output logic                                              regre,
    output logic                                              ex_start,
    output logic                                              dmem_re,
    output logic                                              dmem_we,
    output logic                                              regwe,
    output logic [((PCMUX_N > 1) ? $clog2(PCMUX_N) : 1)-1:0] pcmuxctl,
    output logic                                              pcnextctl,
    output logic                                              retire,
    output logic                                              trap,
    output logic [1:0]                                        trap_cause,
    output logic [2:0]                                        state_o
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]                                  cycle_cnt,
    output logic [CNT_W-1:0]                                  instret_cnt
`endif
);

    localparam int PCW = (PCMUX_N > 1) ? $clog2(PCMUX_N) : 1;
    localparam int WCW = $clog2(TIMEOUT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    if (TIMEOUT < 2) begin : g_badTimeout
        $error("multicycle_ctrl: TIMEOUT must be at least 2");
    end
    if (PCMUX_N < 2) begin : g_badPcmux
        $error("multicycle_ctrl: PCMUX_N must be at least 2");
    end
    if (CNT_W < 1) begin : g_badCntW
        $error("multicycle_ctrl: CNT_W must be at least 1");
    end

    typedef enum logic [2:0] {
        S_BOOT = 3'b000,
        S_IF   = 3'b001,
        S_ID   = 3'b010,
        S_EX   = 3'b011,
        S_MEM  = 3'b100,
        S_WB   = 3'b101,
        S_TRAP = 3'b110
    } state_t;

    state_t           state_q;
    logic [WCW-1:0]   waitCnt_q;
    logic             isLoad_q;
    logic             isStore_q;
    logic             isBranch_q;
    logic             isJump_q;
    logic             instrre_q;
    logic             regre_q;
    logic             exStart_q;
    logic             dmemRe_q;
    logic             dmemWe_q;
    logic             regwe_q;
    logic [PCW-1:0]   pcmux_q;
    logic             pcnext_q;
    logic             retire_q;
    logic             trap_q;
    logic [1:0]       cause_q;

    logic opLegal;
    logic waitExpired;

    always_comb begin
        opLegal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opLegal = 1'b1;
            default:                           opLegal = 1'b0;
        endcase
    end

    // Reaching TIMEOUT-1 without an ack means this is the last allowed waiting cycle.
    assign waitExpired = (waitCnt_q == WCW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            waitCnt_q  <= '0;
            isLoad_q   <= 1'b0;
            isStore_q  <= 1'b0;
            isBranch_q <= 1'b0;
            isJump_q   <= 1'b0;
            instrre_q  <= 1'b0;
            regre_q    <= 1'b0;
            exStart_q  <= 1'b0;
            dmemRe_q   <= 1'b0;
            dmemWe_q   <= 1'b0;
            regwe_q    <= 1'b0;
            pcmux_q    <= '0;
            pcnext_q   <= 1'b0;
            retire_q   <= 1'b0;
            trap_q     <= 1'b0;
            cause_q    <= 2'b00;
        end else begin
            regre_q   <= 1'b0;
            exStart_q <= 1'b0;
            regwe_q   <= 1'b0;
            pcnext_q  <= 1'b0;
            retire_q  <= 1'b0;
            case (state_q)
                S_BOOT: begin
                    state_q   <= S_IF;
                    instrre_q <= 1'b1;
                    waitCnt_q <= '0;
                end
                S_IF: begin
                    if (imem_ack) begin
                        state_q   <= S_ID;
                        instrre_q <= 1'b0;
                        regre_q   <= 1'b1;
                    end else if (waitExpired) begin
                        state_q   <= S_TRAP;
                        instrre_q <= 1'b0;
                        trap_q    <= 1'b1;
                        cause_q   <= CAUSE_TIMEOUT;
                    end else begin
                        waitCnt_q <= waitCnt_q + WCW'(1);
                    end
                end
                S_ID: begin
                    // Instruction class is latched here so EX/MEM/WB do not depend on opcode staying valid.
                    if (opLegal) begin
                        state_q    <= S_EX;
                        exStart_q  <= 1'b1;
                        waitCnt_q  <= '0;
                        isLoad_q   <= (opcode == OP_LOAD);
                        isStore_q  <= (opcode == OP_STORE);
                        isBranch_q <= (opcode == OP_BRANCH);
                        isJump_q   <= (opcode == OP_JAL) || (opcode == OP_JALR);
                    end else begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_ILLEGAL;
                    end
                end
                S_EX: begin
                    if (ex_valid) begin
                        if (isLoad_q || isStore_q) begin
                            state_q   <= S_MEM;
                            dmemRe_q  <= isLoad_q;
                            dmemWe_q  <= isStore_q;
                            waitCnt_q <= '0;
                        end else if (isBranch_q) begin
                            state_q   <= S_IF;
                            instrre_q <= 1'b1;
                            waitCnt_q <= '0;
                            pcmux_q   <= PCW'(br_taken);
                            pcnext_q  <= 1'b1;
                            retire_q  <= 1'b1;
                        end else begin
                            state_q <= S_WB;
                            regwe_q <= 1'b1;
                        end
                    end else if (waitExpired) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        waitCnt_q <= waitCnt_q + WCW'(1);
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmemRe_q <= 1'b0;
                        dmemWe_q <= 1'b0;
                        if (isLoad_q) begin
                            state_q <= S_WB;
                            regwe_q <= 1'b1;
                        end else begin
                            state_q   <= S_IF;
                            instrre_q <= 1'b1;
                            waitCnt_q <= '0;
                            pcmux_q   <= '0;
                            pcnext_q  <= 1'b1;
                            retire_q  <= 1'b1;
                        end
                    end else if (waitExpired) begin
                        state_q  <= S_TRAP;
                        dmemRe_q <= 1'b0;
                        dmemWe_q <= 1'b0;
                        trap_q   <= 1'b1;
                        cause_q  <= CAUSE_TIMEOUT;
                    end else begin
                        waitCnt_q <= waitCnt_q + WCW'(1);
                    end
                end
                S_WB: begin
                    // pcmuxctl only moves together with pcnextctl, so a jump's target select is applied here.
                    state_q   <= S_IF;
                    instrre_q <= 1'b1;
                    waitCnt_q <= '0;
                    pcmux_q   <= PCW'(isJump_q);
                    pcnext_q  <= 1'b1;
                    retire_q  <= 1'b1;
                end
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    assign instrre    = instrre_q;
    assign regre      = regre_q;
    assign ex_start   = exStart_q;
    assign dmem_re    = dmemRe_q;
    assign dmem_we    = dmemWe_q;
    assign regwe      = regwe_q;
    assign pcmuxctl   = pcmux_q;
    assign pcnextctl  = pcnext_q;
    assign retire     = retire_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state_o    = state_q;

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] cycleCnt_q;
    logic [CNT_W-1:0] instretCnt_q;

    // Counters wrap naturally; cycle counting freezes once the core is trapped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCnt_q   <= '0;
            instretCnt_q <= '0;
        end else begin
            if (state_q != S_TRAP) begin
                cycleCnt_q <= cycleCnt_q + CNT_W'(1);
            end
            if (retire_q) begin
                instretCnt_q <= instretCnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycleCnt_q;
    assign instret_cnt = instretCnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: a default instance plus a TIMEOUT=4 instance on shared inputs.
module tb_multicycle_ctrl;

    localparam logic [2:0] S_BOOT = 3'b000;
    localparam logic [2:0] S_IF   = 3'b001;
    localparam logic [2:0] S_ID   = 3'b010;
    localparam logic [2:0] S_EX   = 3'b011;
    localparam logic [2:0] S_MEM  = 3'b100;
    localparam logic [2:0] S_WB   = 3'b101;
    localparam logic [2:0] S_TRAP = 3'b110;

    localparam logic [9:0] F_NONE = 10'b0000000000;
    localparam logic [9:0] F_IR   = 10'b1000000000;
    localparam logic [9:0] F_RRE  = 10'b0100000000;
    localparam logic [9:0] F_EXS  = 10'b0010000000;
    localparam logic [9:0] F_DRE  = 10'b0001000000;
    localparam logic [9:0] F_DWE  = 10'b0000100000;
    localparam logic [9:0] F_RWE  = 10'b0000010000;
    localparam logic [9:0] F_PCM  = 10'b0000001000;
    localparam logic [9:0] F_PCN  = 10'b0000000100;
    localparam logic [9:0] F_RET  = 10'b0000000010;
    localparam logic [9:0] F_TRP  = 10'b0000000001;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       brTaken;
    logic       imemAck;
    logic       exValid;
    logic       dmemAck;

    logic       aInstrre, aRegre, aExStart, aDmemRe, aDmemWe, aRegwe, aPcmux, aPcnext, aRetire, aTrap;
    logic [1:0] aCause;
    logic [2:0] aState;
    logic       bInstrre, bRegre, bExStart, bDmemRe, bDmemWe, bRegwe, bPcmux, bPcnext, bRetire, bTrap;
    logic [1:0] bCause;
    logic [2:0] bState;

    logic [14:0] obsA;
    logic [14:0] obsB;

    typedef struct {
        string       tag;
        logic [14:0] expA;
        bit          useB;
        logic [14:0] expB;
    } expItem_t;

    expItem_t sbQueue[$];
    int checkCount = 0;
    int passCount  = 0;

    multicycle_ctrl #(.PCMUX_N(2), .TIMEOUT(32), .CNT_W(32)) dutMain (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(brTaken),
        .imem_ack(imemAck), .ex_valid(exValid), .dmem_ack(dmemAck),
        .instrre(aInstrre), .regre(aRegre), .ex_start(aExStart),
        .dmem_re(aDmemRe), .dmem_we(aDmemWe), .regwe(aRegwe),
        .pcmuxctl(aPcmux), .pcnextctl(aPcnext), .retire(aRetire),
        .trap(aTrap), .trap_cause(aCause), .state_o(aState)
    );

    multicycle_ctrl #(.PCMUX_N(2), .TIMEOUT(4), .CNT_W(32)) dutWd (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(brTaken),
        .imem_ack(imemAck), .ex_valid(exValid), .dmem_ack(dmemAck),
        .instrre(bInstrre), .regre(bRegre), .ex_start(bExStart),
        .dmem_re(bDmemRe), .dmem_we(bDmemWe), .regwe(bRegwe),
        .pcmuxctl(bPcmux), .pcnextctl(bPcnext), .retire(bRetire),
        .trap(bTrap), .trap_cause(bCause), .state_o(bState)
    );

    assign obsA = {aState, aInstrre, aRegre, aExStart, aDmemRe, aDmemWe, aRegwe,
                   aPcmux, aPcnext, aRetire, aTrap, aCause};
    assign obsB = {bState, bInstrre, bRegre, bExStart, bDmemRe, bDmemWe, bRegwe,
                   bPcmux, bPcnext, bRetire, bTrap, bCause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ev(input logic [2:0] st, input logic [9:0] fl, input logic [1:0] cause);
        return {st, fl, cause};
    endfunction

    // Pops the oldest expectation and compares it with what the DUTs show now.
    task automatic checkOutput();
        expItem_t item;
        item = sbQueue.pop_front();
        checkCount++;
        assert (obsA === item.expA) passCount++;
        else $error("[TB] FAIL %s dutMain observed=%b required=%b", item.tag, obsA, item.expA);
        if (item.useB) begin
            checkCount++;
            assert (obsB === item.expB) passCount++;
            else $error("[TB] FAIL %s dutWd observed=%b required=%b", item.tag, obsB, item.expB);
        end
    endtask

    // Drives one cycle of inputs, records the outputs expected after the next edge, then checks them.
    task automatic applyStimulus(input string tag, input logic rstV, input logic imemV, input logic exV,
                                 input logic dmemV, input logic brV, input logic [14:0] expA,
                                 input bit useB = 1'b0, input logic [14:0] expB = '0);
        rst     = rstV;
        imemAck = imemV;
        exValid = exV;
        dmemAck = dmemV;
        brTaken = brV;
        sbQueue.push_back('{tag: tag, expA: expA, useB: useB, expB: expB});
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; imemAck = 1'b0; exValid = 1'b0; dmemAck = 1'b0; brTaken = 1'b0; opcode = 7'b0;

        applyStimulus("reset0", 1, 0, 0, 0, 0, ev(S_BOOT, F_NONE, 2'b00), 1, ev(S_BOOT, F_NONE, 2'b00));
        applyStimulus("reset1", 1, 1, 1, 1, 1, ev(S_BOOT, F_NONE, 2'b00), 1, ev(S_BOOT, F_NONE, 2'b00));
        applyStimulus("reset2", 1, 0, 0, 0, 0, ev(S_BOOT, F_NONE, 2'b00), 1, ev(S_BOOT, F_NONE, 2'b00));
        applyStimulus("boot-to-if", 0, 0, 0, 0, 0, ev(S_IF, F_IR, 2'b00), 1, ev(S_IF, F_IR, 2'b00));

        opcode = OP_R;
        applyStimulus("r-if-ack", 0, 1, 0, 0, 0, ev(S_ID, F_RRE, 2'b00));
        applyStimulus("r-id", 0, 0, 0, 1, 0, ev(S_EX, F_EXS, 2'b00));
        applyStimulus("r-ex-valid", 0, 0, 1, 0, 0, ev(S_WB, F_RWE, 2'b00));
        applyStimulus("r-wb", 0, 0, 0, 0, 0, ev(S_IF, F_IR | F_PCN | F_RET, 2'b00));
        applyStimulus("r-if-idle", 0, 0, 0, 0, 0, ev(S_IF, F_IR, 2'b00));

        opcode = OP_LOAD;
        applyStimulus("ld-if-ack", 0, 1, 0, 0, 0, ev(S_ID, F_RRE, 2'b00));
        applyStimulus("ld-id", 0, 0, 0, 0, 0, ev(S_EX, F_EXS, 2'b00));
        applyStimulus("ld-ex-valid", 0, 0, 1, 0, 0, ev(S_MEM, F_DRE, 2'b00));
        for (int i = 0; i < 5; i++) begin
            applyStimulus("ld-mem-wait", 0, 0, 0, 0, 0, ev(S_MEM, F_DRE, 2'b00));
        end
        applyStimulus("ld-mem-ack", 0, 0, 0, 1, 0, ev(S_WB, F_RWE, 2'b00));
        applyStimulus("ld-wb", 0, 0, 0, 0, 0, ev(S_IF, F_IR | F_PCN | F_RET, 2'b00));

        opcode = OP_BRANCH;
        applyStimulus("br-if-ack", 0, 1, 0, 0, 0, ev(S_ID, F_RRE, 2'b00));
        applyStimulus("br-id", 0, 0, 0, 0, 0, ev(S_EX, F_EXS, 2'b00));
        applyStimulus("br-ex-taken", 0, 0, 1, 0, 1, ev(S_IF, F_IR | F_PCM | F_PCN | F_RET, 2'b00));
        applyStimulus("br-if-idle", 0, 0, 0, 0, 0, ev(S_IF, F_IR | F_PCM, 2'b00));

        opcode = OP_STORE;
        applyStimulus("st-if-ack", 0, 1, 0, 0, 0, ev(S_ID, F_RRE | F_PCM, 2'b00));
        applyStimulus("st-id", 0, 0, 0, 0, 0, ev(S_EX, F_EXS | F_PCM, 2'b00));
        applyStimulus("st-ex-valid", 0, 0, 1, 0, 0, ev(S_MEM, F_DWE | F_PCM, 2'b00));
        applyStimulus("st-mem-wait", 0, 1, 0, 0, 0, ev(S_MEM, F_DWE | F_PCM, 2'b00));
        applyStimulus("st-mem-ack", 0, 0, 0, 1, 0, ev(S_IF, F_IR | F_PCN | F_RET, 2'b00));

        opcode = OP_JAL;
        applyStimulus("jal-if-ack", 0, 1, 0, 0, 0, ev(S_ID, F_RRE, 2'b00));
        applyStimulus("jal-id", 0, 0, 0, 0, 0, ev(S_EX, F_EXS, 2'b00));
        applyStimulus("jal-ex-wait", 0, 0, 0, 0, 0, ev(S_EX, F_NONE, 2'b00));
        applyStimulus("jal-ex-valid", 0, 0, 1, 0, 0, ev(S_WB, F_RWE, 2'b00));
        applyStimulus("jal-wb", 0, 0, 0, 0, 0, ev(S_IF, F_IR | F_PCM | F_PCN | F_RET, 2'b00));

        opcode = OP_BAD;
        applyStimulus("ill-if-ack", 0, 1, 0, 0, 0, ev(S_ID, F_RRE | F_PCM, 2'b00));
        applyStimulus("ill-id", 0, 0, 0, 0, 0, ev(S_TRAP, F_PCM | F_TRP, 2'b01));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("ill-trap-hold", 0, 1, 1, 1, 0, ev(S_TRAP, F_PCM | F_TRP, 2'b01));
        end

        opcode = OP_R;
        applyStimulus("wd-reset", 1, 0, 0, 0, 0, ev(S_BOOT, F_NONE, 2'b00), 1, ev(S_BOOT, F_NONE, 2'b00));
        applyStimulus("wd-boot", 0, 0, 0, 0, 0, ev(S_IF, F_IR, 2'b00), 1, ev(S_IF, F_IR, 2'b00));
        applyStimulus("wd-if-ack", 0, 1, 0, 0, 0, ev(S_ID, F_RRE, 2'b00), 1, ev(S_ID, F_RRE, 2'b00));
        applyStimulus("wd-id", 0, 0, 0, 0, 0, ev(S_EX, F_EXS, 2'b00), 1, ev(S_EX, F_EXS, 2'b00));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("wd-ex-wait", 0, 0, 0, 0, 0, ev(S_EX, F_NONE, 2'b00), 1, ev(S_EX, F_NONE, 2'b00));
        end
        applyStimulus("wd-ex-expire", 0, 0, 0, 0, 0, ev(S_EX, F_NONE, 2'b00), 1, ev(S_TRAP, F_TRP, 2'b10));
        applyStimulus("wd-trap-hold", 0, 0, 1, 0, 0, ev(S_WB, F_RWE, 2'b00), 1, ev(S_TRAP, F_TRP, 2'b10));

        applyStimulus("wd2-reset", 1, 0, 0, 0, 0, ev(S_BOOT, F_NONE, 2'b00), 1, ev(S_BOOT, F_NONE, 2'b00));
        applyStimulus("wd2-boot", 0, 0, 0, 0, 0, ev(S_IF, F_IR, 2'b00), 1, ev(S_IF, F_IR, 2'b00));
        applyStimulus("wd2-if-ack", 0, 1, 0, 0, 0, ev(S_ID, F_RRE, 2'b00), 1, ev(S_ID, F_RRE, 2'b00));
        applyStimulus("wd2-id", 0, 0, 0, 0, 0, ev(S_EX, F_EXS, 2'b00), 1, ev(S_EX, F_EXS, 2'b00));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("wd2-ex-wait", 0, 0, 0, 0, 0, ev(S_EX, F_NONE, 2'b00), 1, ev(S_EX, F_NONE, 2'b00));
        end
        applyStimulus("wd2-ack-at-limit", 0, 0, 1, 0, 0, ev(S_WB, F_RWE, 2'b00), 1, ev(S_WB, F_RWE, 2'b00));
        applyStimulus("wd2-wb", 0, 0, 0, 0, 0, ev(S_IF, F_IR | F_PCN | F_RET, 2'b00), 1,
                      ev(S_IF, F_IR | F_PCN | F_RET, 2'b00));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("wd2-if-wait", 0, 0, 0, 0, 0, ev(S_IF, F_IR, 2'b00), 1, ev(S_IF, F_IR, 2'b00));
        end
        applyStimulus("wd2-if-expire", 0, 0, 0, 0, 0, ev(S_IF, F_IR, 2'b00), 1, ev(S_TRAP, F_TRP, 2'b10));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
